// File: rtl/ifetch_queue.sv
// Fetch front-end: one outstanding I-cache line request, circular instruction queue, prioritised redirects.
// Latency: response to out_valid 1 cycle; 0 cycles when built with IFQ_BYPASS_EN and the queue is empty.
// Backpressure: out_ready low holds the head; no new request while free slots < FETCH_WIDTH.
`ifndef NOP
`define NOP 32'h0000_0013
`endif

module ifetch_queue #(
    parameter int              XLEN         = 32,
    parameter int              QUEUE_DEPTH  = 8,
    parameter int              FETCH_WIDTH  = 2,
    parameter int              NUM_REDIRECT = 3,
    parameter logic [XLEN-1:0] RESET_PC     = '0
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [NUM_REDIRECT-1:0]          redirect_req,
    input  logic [NUM_REDIRECT*XLEN-1:0]     redirect_pc,
    output logic [XLEN-1:0]                  proc2Icache_addr,
    output logic                             proc2Icache_req,
    input  logic [63:0]                      Icache2proc_data,
    input  logic                             Icache2proc_data_valid,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [XLEN-1:0]                  out_inst,
    output logic [XLEN-1:0]                  out_pc,
    output logic [XLEN-1:0]                  out_npc,
    output logic [$clog2(QUEUE_DEPTH):0]     q_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [PW-1:0]   r_head, r_tail;
    logic [CW-1:0]   r_count;
    logic            r_req;
    logic [XLEN-1:0] r_inst [QUEUE_DEPTH];
    logic [XLEN-1:0] r_pc   [QUEUE_DEPTH];

    logic            w_any_redir;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_space_ok, w_issue, w_accept, w_two, w_byp;
    logic            w_wr0, w_wr1, w_deq, w_q_vld;
    logic [PW-1:0]   w_tail1;
    logic [CW-1:0]   w_n_wr;
    logic [XLEN-1:0] w_slot0, w_slot1;
    logic [XLEN-1:0] w_head_inst, w_head_pc, w_head_npc;

    assign w_any_redir = |redirect_req;

    // Later (higher) channels override earlier ones.
    always_comb begin
        w_redir_pc = redirect_pc[0 +: XLEN];
        for (int i = 1; i < NUM_REDIRECT; i++) begin
            if (redirect_req[i]) w_redir_pc = redirect_pc[i*XLEN +: XLEN];
        end
    end

    assign w_space_ok = (CW'(QUEUE_DEPTH) - r_count) >= CW'(FETCH_WIDTH);
    assign w_issue    = (r_state == S_IDLE) && !w_any_redir && w_space_ok;
    assign w_accept   = (r_state == S_WAIT) && Icache2proc_data_valid && !w_any_redir;
    assign w_two      = (FETCH_WIDTH == 2) && !r_fetch_pc[2];
    assign w_slot0    = r_fetch_pc[2] ? XLEN'(Icache2proc_data[63:32]) : XLEN'(Icache2proc_data[31:0]);
    assign w_slot1    = XLEN'(Icache2proc_data[63:32]);

`ifdef IFQ_BYPASS_EN
    assign w_byp = w_accept && (r_count == '0) && out_ready;
`else
    assign w_byp = 1'b0;
`endif

    assign w_wr0   = w_accept && !w_byp;
    assign w_wr1   = w_accept && w_two;
    assign w_n_wr  = CW'(w_wr0) + CW'(w_wr1);
    assign w_tail1 = r_tail + PW'(w_wr0);
    assign w_q_vld = (r_count != '0) && !w_any_redir;
    assign w_deq   = w_q_vld && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_issue) w_state_nxt = S_WAIT;
            // A response coinciding with a redirect is consumed (and dropped) here.
            S_WAIT: begin
                if (Icache2proc_data_valid) w_state_nxt = S_IDLE;
                else if (w_any_redir)       w_state_nxt = S_DISCARD;
            end
            S_DISCARD: if (Icache2proc_data_valid) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_req      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_issue;
            if (w_any_redir) begin
                r_count    <= '0;
                r_head     <= r_tail;
                r_fetch_pc <= w_redir_pc;
            end else begin
                r_tail  <= r_tail + PW'(w_wr0) + PW'(w_wr1);
                r_head  <= r_head + PW'(w_deq);
                r_count <= r_count + w_n_wr - CW'(w_deq);
                if (w_accept) r_fetch_pc <= r_fetch_pc + (w_two ? XLEN'(8) : XLEN'(4));
            end
        end
    end

    // Storage needs no reset: entries are only read when r_count says they are valid.
    always_ff @(posedge clock) begin
        if (w_wr0) begin
            r_inst[r_tail] <= w_slot0;
            r_pc[r_tail]   <= r_fetch_pc;
        end
        if (w_wr1) begin
            r_inst[w_tail1] <= w_slot1;
            r_pc[w_tail1]   <= r_fetch_pc + XLEN'(4);
        end
    end

    assign w_head_inst = (r_count != '0) ? r_inst[r_head] : XLEN'(`NOP);
    assign w_head_pc   = (r_count != '0) ? r_pc[r_head] : '0;
    assign w_head_npc  = (r_count != '0) ? r_pc[r_head] + XLEN'(4) : '0;

`ifdef IFQ_BYPASS_EN
    assign out_valid = w_q_vld || w_byp;
    assign out_inst  = w_byp ? w_slot0 : w_head_inst;
    assign out_pc    = w_byp ? r_fetch_pc : w_head_pc;
    assign out_npc   = w_byp ? r_fetch_pc + XLEN'(4) : w_head_npc;
`else
    assign out_valid = w_q_vld;
    assign out_inst  = w_head_inst;
    assign out_pc    = w_head_pc;
    assign out_npc   = w_head_npc;
`endif

    assign proc2Icache_req  = r_req;
    assign proc2Icache_addr = {r_fetch_pc[XLEN-1:3], 3'b000};
    assign q_count          = r_count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (default parameters) with an expected-instruction scoreboard.
module tb_ifetch_queue;

    localparam bit BYP =
`ifdef IFQ_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  redirect_req;
    logic [95:0] redirect_pc;
    logic [31:0] proc2Icache_addr;
    logic        proc2Icache_req;
    logic [63:0] Icache2proc_data;
    logic        Icache2proc_data_valid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic [3:0]  q_count;

    ifetch_queue dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .redirect_req           (redirect_req),
        .redirect_pc            (redirect_pc),
        .proc2Icache_addr       (proc2Icache_addr),
        .proc2Icache_req        (proc2Icache_req),
        .Icache2proc_data       (Icache2proc_data),
        .Icache2proc_data_valid (Icache2proc_data_valid),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_inst               (out_inst),
        .out_pc                 (out_pc),
        .out_npc                (out_npc),
        .q_count                (q_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] req_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;

    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_BAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] line(input logic [31:0] a);
        return {32'hC000_0000 | (a + 32'd4), 32'hC000_0000 | a};
    endfunction

    // Reference model of what one accepted line contributes to the queue.
    task automatic model_push(input logic [63:0] d);
        if (m_pc[2]) begin
            sb.push_back({d[63:32], m_pc});
            m_pc = m_pc + 32'd4;
        end else begin
            sb.push_back({d[31:0], m_pc});
            sb.push_back({d[63:32], m_pc + 32'd4});
            m_pc = m_pc + 32'd8;
        end
    endtask

    task automatic mon();
        exp_t e;
        if (proc2Icache_req) req_q.push_back(proc2Icache_addr);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_xfer", 64'(out_valid), 64'(1'b0));
            end else begin
                e = sb.pop_front();
                chk("out_pc",   64'(out_pc),   64'(e.pc));
                chk("out_inst", 64'(out_inst), 64'(e.inst));
                chk("out_npc",  64'(out_npc),  64'(e.pc + 32'd4));
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        mon();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] a);
        int n = 0;
        while (req_q.size() == 0 && n < 40) begin
            tick();
            n++;
        end
        if (req_q.size() == 0) chk("req_timeout", 64'(req_q.size()), 64'(1));
        else                   chk("req_addr", 64'(req_q.pop_front()), 64'(a));
    endtask

    task automatic respond(input logic [31:0] a, input bit keep);
        Icache2proc_data       = keep ? line(a) : JUNK;
        Icache2proc_data_valid = 1'b1;
        if (keep) model_push(line(a));
        tick();
        Icache2proc_data_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("drain_left", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        reset_n                = 1'b0;
        redirect_req           = '0;
        redirect_pc            = '0;
        Icache2proc_data       = '0;
        Icache2proc_data_valid = 1'b0;
        out_ready              = 1'b0;
        m_pc                   = 32'h0;

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_out_inst",  64'(out_inst),  64'(32'h13));
        chk("rst_out_pc",    64'(out_pc),    64'(0));
        chk("rst_out_npc",   64'(out_npc),   64'(0));
        chk("rst_req",       64'(proc2Icache_req), 64'(1'b0));
        chk("rst_count",     64'(q_count),   64'(0));
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Streaming two lines
        out_ready = 1'b1;
        wait_req(32'h0);
        respond(32'h0, 1'b1);
        wait_req(32'h8);
        respond(32'h8, 1'b1);
        drain();
        chk("stream_count", 64'(q_count), 64'(0));

        // Redirect while waiting: old response discarded, single insn at 0x104
        wait_req(32'h10);
        redirect_pc[0 +: 32] = 32'h104;
        redirect_req = 3'b001;
        tick();
        redirect_req = '0;
        m_pc = 32'h104;
        respond(32'h10, 1'b0);
        wait_req(32'h100);
        respond(32'h100, 1'b1);
        wait_req(32'h108);
        drain();

        // Backpressure: fill to 8, no request while full, then drain with wrap
        out_ready = 1'b0;
        respond(32'h108, 1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_req({m_pc[31:3], 3'b000});
            respond({m_pc[31:3], 3'b000}, 1'b1);
        end
        repeat (10) tick();
        chk("full_no_req",  64'(req_q.size()), 64'(0));
        chk("full_count",   64'(q_count), 64'(8));
        chk("full_valid",   64'(out_valid), 64'(1'b1));
        out_ready = 1'b1;
        drain();
        wait_req(32'h128);
        chk("drained_count", 64'(q_count), 64'(0));

        // Two channels at once in WAIT: channel 2 wins, queue flushed, late response dropped
        out_ready = 1'b0;
        respond(32'h128, 1'b1);
        wait_req(32'h130);
        chk("pre_flush_count", 64'(q_count), 64'(2));
        redirect_pc[0 +: 32]  = 32'h40;
        redirect_pc[64 +: 32] = 32'h80;
        redirect_req = 3'b101;
        tick();
        redirect_req = '0;
        sb.delete();
        m_pc = 32'h80;
        chk("flush_count", 64'(q_count), 64'(0));
        chk("flush_valid", 64'(out_valid), 64'(1'b0));
        respond(32'h130, 1'b0);
        chk("late_drop_count", 64'(q_count), 64'(0));
        wait_req(32'h80);

        // Redirect in the same cycle as the response
        respond(32'h80, 1'b1);
        wait_req(32'h88);
        out_ready = 1'b1;
        redirect_pc[32 +: 32] = 32'h200;
        redirect_req = 3'b010;
        Icache2proc_data = line(32'h88);
        Icache2proc_data_valid = 1'b1;
        @(negedge clock);
        chk("redir_resp_valid", 64'(out_valid), 64'(1'b0));
        mon();
        @(posedge clock);
        #1;
        redirect_req = '0;
        Icache2proc_data_valid = 1'b0;
        sb.delete();
        m_pc = 32'h200;
        chk("redir_resp_count", 64'(q_count), 64'(0));
        wait_req(32'h200);

        // Asynchronous reset mid-WAIT with a stale response after release
        out_ready = 1'b0;
        respond(32'h200, 1'b1);
        wait_req(32'h208);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", 64'(q_count), 64'(0));
        chk("arst_valid", 64'(out_valid), 64'(1'b0));
        chk("arst_pc",    64'(out_pc), 64'(0));
        chk("arst_inst",  64'(out_inst), 64'(32'h13));
        chk("arst_req",   64'(proc2Icache_req), 64'(1'b0));
        sb.delete();
        req_q.delete();
        m_pc = 32'h0;
        tick();
        reset_n = 1'b1;
        respond(32'h208, 1'b0);
        chk("stale_count", 64'(q_count), 64'(0));
        wait_req(32'h0);

        // Response into an empty queue with out_ready high
        out_ready = 1'b1;
        Icache2proc_data = line(32'h0);
        Icache2proc_data_valid = 1'b1;
        model_push(line(32'h0));
        @(negedge clock);
        chk("resp_cycle_valid", 64'(out_valid), 64'(BYP));
        mon();
        @(posedge clock);
        #1;
        Icache2proc_data_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
